// File: rtl/ucsbece154a_memarb_if.sv
// rtl/ucsbece154a_memarb_if.sv - one master's request/response bundle for the memory arbiter
interface ucsbece154a_memarb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] adr;
  logic [DW-1:0] wd;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rd;

  modport master (output req, we, lock, adr, wd, input gnt, rvalid, rd);
  modport slave  (input req, we, lock, adr, wd, output gnt, rvalid, rd);
endinterface

// File: rtl/ucsbece154a_memarb.sv
// rtl/ucsbece154a_memarb.sv - round-robin two-master arbiter with bounded lock for the unified memory
module ucsbece154a_memarb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXLOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  ucsbece154a_memarb_if.slave m0,
  ucsbece154a_memarb_if.slave m1,
  output logic                mem_we_o,
  output logic [AW-1:0]       mem_adr_o,
  output logic [DW-1:0]       mem_wd_o,
  input  logic [DW-1:0]       mem_rd_i
);
  localparam int CW = $clog2(MAXLOCK + 1);

  logic          last_q, last_d;
  logic          lock_vld_q, lock_vld_d;
  logic          lock_own_q, lock_own_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rv0_q, rv0_d, rv1_q, rv1_d;
  logic          gnt0, gnt1, any_gnt, sel_we, sel_lock;
  logic          own_req, oth_req, force_rel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
      rdata_q    <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      rdata_q    <= rdata_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

  always_comb begin
    own_req   = lock_own_q ? m1.req : m0.req;
    oth_req   = lock_own_q ? m0.req : m1.req;
    // A saturated lock yields only when someone is actually waiting for it.
    force_rel = lock_vld_q && (lock_cnt_q >= CW'(MAXLOCK)) && oth_req;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (reset) begin
      if (lock_vld_q && own_req && !force_rel) begin
        gnt1 = lock_own_q;
        gnt0 = !lock_own_q;
      end else if (lock_vld_q && oth_req) begin
        gnt1 = !lock_own_q;
        gnt0 = lock_own_q;
      end else if (m0.req && m1.req) begin
        gnt1 = !last_q;
        gnt0 = last_q;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end

    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? m1.we   : m0.we;
    sel_lock  = gnt1 ? m1.lock : m0.lock;
    mem_adr_o = gnt1 ? m1.adr  : m0.adr;
    mem_wd_o  = gnt1 ? m1.wd   : m0.wd;
    mem_we_o  = any_gnt & sel_we;

    last_d     = any_gnt ? gnt1 : last_q;
    lock_vld_d = 1'b0;
    lock_own_d = lock_own_q;
    lock_cnt_d = '0;
    if (any_gnt && sel_lock) begin
      lock_vld_d = 1'b1;
      lock_own_d = gnt1;
      if (lock_vld_q && (lock_own_q == gnt1))
        lock_cnt_d = (lock_cnt_q >= CW'(MAXLOCK)) ? lock_cnt_q : lock_cnt_q + CW'(1);
      else
        lock_cnt_d = CW'(1);
    end

    rdata_d = (any_gnt && !sel_we) ? mem_rd_i : rdata_q;
    rv0_d   = gnt0 & !m0.we;
    rv1_d   = gnt1 & !m1.we;
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rv0_q;
  assign m1.rvalid = rv1_q;
  assign m0.rd     = rdata_q;
  assign m1.rd     = rdata_q;
endmodule
